// File: rtl/alu_share_arbiter.sv
// Round-robin scheduler sharing one 16-bit signed adder with status flags among N requesters.
// Result, flags and requester tag are registered one cycle after the grant.
module alu_share_arbiter #(
  parameter int  N   = 4,
  parameter bit  SAT = 1'b0,
  localparam int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [16*N-1:0]  req_x,
  input  logic [16*N-1:0]  req_y,
  output logic [N-1:0]     req_ready,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [15:0]      rsp_z,
  output logic             rsp_sign,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_parity,
  output logic             rsp_overflow,
  output logic [15:0]      ovf_count
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic           w_xfer;
  logic [15:0]    w_x;
  logic [15:0]    w_y;
  logic [16:0]    w_sum;
  logic [15:0]    w_raw;
  logic           w_ovf;
  logic [15:0]    w_z;
  logic [IDW-1:0] w_ptr_next;

  // Search starts at the pointer and wraps, so the last winner is visited last.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % N]) begin
        w_found = 1'b1;
        w_idx   = IDW'((int'(r_ptr) + k) % N);
      end
    end
  end

  assign w_xfer     = w_found & ~rst;
  assign req_ready  = w_xfer ? (N'(1) << w_idx) : '0;
  assign w_ptr_next = IDW'((int'(w_idx) + 1) % N);

  assign w_x   = req_x[16*int'(w_idx) +: 16];
  assign w_y   = req_y[16*int'(w_idx) +: 16];
  assign w_sum = {1'b0, w_x} + {1'b0, w_y};
  assign w_raw = w_sum[15:0];
  assign w_ovf = (w_x[15] & w_y[15] & ~w_raw[15]) | (~w_x[15] & ~w_y[15] & w_raw[15]);

  // Saturation direction follows the operand sign (both operands share it on overflow).
  always_comb begin
    w_z = w_raw;
    if (SAT && w_ovf) w_z = w_x[15] ? 16'h8000 : 16'h7FFF;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_z        <= '0;
      rsp_sign     <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_parity   <= 1'b0;
      rsp_overflow <= 1'b0;
      ovf_count    <= '0;
    end else begin
      rsp_valid <= w_xfer;
      if (w_xfer) begin
        r_ptr        <= w_ptr_next;
        rsp_id       <= w_idx;
        rsp_z        <= w_z;
        rsp_sign     <= w_z[15];
        rsp_zero     <= (w_z == 16'h0000);
        rsp_carry    <= w_sum[16];
        rsp_parity   <= ~^w_z;
        rsp_overflow <= w_ovf;
        if (w_ovf && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: wrap and saturating instances share stimulus;
// a model predicts grants and pushes expected results into a scoreboard queue.
module tb_alu_share_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] z0;
    logic        s0, zr0, p0;
    logic [15:0] z1;
    logic        s1, zr1, p1;
    logic        c, o;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_x = '0;
  logic [16*N-1:0] req_y = '0;

  logic [N-1:0] rdy0, rdy1;
  logic         v0, v1;
  logic [1:0]   id0, id1;
  logic [15:0]  z0, z1, oc0, oc1;
  logic         s0, zr0, c0, p0, o0;
  logic         s1, zr1, c1, p1, o1;

  alu_share_arbiter #(.N(N), .SAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(rdy0), .rsp_valid(v0), .rsp_id(id0), .rsp_z(z0),
    .rsp_sign(s0), .rsp_zero(zr0), .rsp_carry(c0), .rsp_parity(p0),
    .rsp_overflow(o0), .ovf_count(oc0)
  );

  alu_share_arbiter #(.N(N), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(rdy1), .rsp_valid(v1), .rsp_id(id1), .rsp_z(z1),
    .rsp_sign(s1), .rsp_zero(zr1), .rsp_carry(c1), .rsp_parity(p1),
    .rsp_overflow(o1), .ovf_count(oc1)
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  exp_t last = '0;
  int   m_ptr = 0;
  logic [15:0] m_ovf = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [1:0] id, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y};
    e.id  = id;
    e.c   = s[16];
    e.o   = (x[15] == y[15]) && (s[15] != x[15]);
    e.z0  = s[15:0];
    e.z1  = e.o ? (x[15] ? 16'h8000 : 16'h7FFF) : s[15:0];
    e.s0  = e.z0[15]; e.zr0 = (e.z0 == 0); e.p0 = ~^e.z0;
    e.s1  = e.z1[15]; e.zr1 = (e.z1 == 0); e.p1 = ~^e.z1;
    return e;
  endfunction

  task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y);
    req_x[16*i +: 16] = x;
    req_y[16*i +: 16] = y;
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic step();
    logic [N-1:0] g;
    bit           xfer;
    int           gi;
    exp_t         e;
    #1;
    g = '0; xfer = 0; gi = 0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (!xfer && req_valid[(m_ptr + k) % N]) begin
          gi = (m_ptr + k) % N;
          g[gi] = 1'b1;
          xfer = 1;
        end
      end
    end
    check("req_ready", 32'(rdy0), 32'(g));
    check("req_ready_sat", 32'(rdy1), 32'(g));
    if (xfer) begin
      e = model(2'(gi), req_x[16*gi +: 16], req_y[16*gi +: 16]);
      sb.push_back(e);
      m_ptr = (gi + 1) % N;
      if (e.o && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
    end
    if (rst) begin
      m_ptr = 0; m_ovf = '0; last = '0; sb.delete();
    end
    @(negedge clk);
    check("rsp_valid", 32'(v0), 32'(xfer));
    check("rsp_valid_sat", 32'(v1), 32'(xfer));
    if (v0) begin
      if (sb.size() == 0) check("scoreboard_empty", 32'(sb.size()), 32'd1);
      else last = sb.pop_front();
    end
    sb.delete();
    check("rsp_id", 32'(id0), 32'(last.id));
    check("rsp_z", 32'(z0), 32'(last.z0));
    check("rsp_sign", 32'(s0), 32'(last.s0));
    check("rsp_zero", 32'(zr0), 32'(last.zr0));
    check("rsp_parity", 32'(p0), 32'(last.p0));
    check("rsp_carry", 32'(c0), 32'(last.c));
    check("rsp_overflow", 32'(o0), 32'(last.o));
    check("rsp_id_sat", 32'(id1), 32'(last.id));
    check("rsp_z_sat", 32'(z1), 32'(last.z1));
    check("rsp_sign_sat", 32'(s1), 32'(last.s1));
    check("rsp_zero_sat", 32'(zr1), 32'(last.zr1));
    check("rsp_parity_sat", 32'(p1), 32'(last.p1));
    check("rsp_carry_sat", 32'(c1), 32'(last.c));
    check("rsp_overflow_sat", 32'(o1), 32'(last.o));
    check("ovf_count", 32'(oc0), 32'(m_ovf));
    check("ovf_count_sat", 32'(oc1), 32'(m_ovf));
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    rst = 1'b1; step(); step();
    rst = 1'b0;

    // Req 0: 0x7FFF + 0x0001 overflows into 0x8000 (wrap) / 0x7FFF (sat)
    req_valid = 4'b0001; set_req(0, 16'h7FFF, 16'h0001); step();
    req_valid = '0; step(); step();

    // Req 2: 0xFFFF + 0x0001 -> zero with carry
    req_valid = 4'b0100; set_req(2, 16'hFFFF, 16'h0001); step();
    req_valid = '0; step();

    // Negative overflow: 0x8000 + 0xFFFF
    req_valid = 4'b0010; set_req(1, 16'h8000, 16'hFFFF); step();
    req_valid = '0; step();

    // All requesters valid from the first cycle after reset
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < N; j++) set_req(j, 16'($urandom), 16'($urandom));
      step();
    end

    // Reqs 1 and 3: advance pointer to 2, reset mid-stream, expect req 1 next
    req_valid = '0; step();
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b1010; set_req(1, 16'h1234, 16'h0F0F); set_req(3, 16'h4000, 16'h4000);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); step();

    // Random valid patterns with withdrawals and boundary operands
    for (int i = 0; i < 40; i++) begin
      req_valid = 4'($urandom);
      for (int j = 0; j < N; j++) begin
        case ($urandom_range(0, 3))
          0: set_req(j, 16'h7FFF, 16'($urandom));
          1: set_req(j, 16'h8000, 16'($urandom));
          default: set_req(j, 16'($urandom), 16'($urandom));
        endcase
      end
      step();
    end

    // ovf_count saturation
    req_valid = '0;
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b0001; set_req(0, 16'h4000, 16'h4000);
    for (int i = 0; i < 65537; i++) step();
    check("ovf_count_final", 32'(oc0), 32'h0000FFFF);
    req_valid = '0; step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
